// File: rtl/clk_pattern_gen_if.sv
// Control/status bundle for clk_pattern_gen.
// The period_cnt member exists only when CLK_PATTERN_GEN_PERIOD_CNT_EN is defined.
interface clk_pattern_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] t_on;
    logic [CNT_W-1:0] t_off;
    logic             clk;
    logic             busy;
    logic             rise_stb;
    logic             fall_stb;
`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
    logic [15:0]      period_cnt;

    modport master (
        output start, stop, phase, t_on, t_off,
        input  clk, busy, rise_stb, fall_stb, period_cnt
    );
    modport slave (
        input  start, stop, phase, t_on, t_off,
        output clk, busy, rise_stb, fall_stb, period_cnt
    );
`else
    modport master (
        output start, stop, phase, t_on, t_off,
        input  clk, busy, rise_stb, fall_stb
    );
    modport slave (
        input  start, stop, phase, t_on, t_off,
        output clk, busy, rise_stb, fall_stb
    );
`endif
endinterface

// File: rtl/clk_pattern_gen.sv
// Programmable clock-pattern generator: phase delay, then high/low times counted in ref_clk cycles.
// Define CLK_PATTERN_GEN_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clk_pattern_gen #(
    parameter int CNT_W = 8
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    clk_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stop_pend, stop_pend_nxt;
    logic [CNT_W-1:0] on_m1, off_m1;
    logic             accept;

    logic clk_q, busy_q, rise_q, fall_q;
    logic clk_nxt, busy_nxt, rise_nxt, fall_nxt;

    // Zero-length high/low times are stretched to a single cycle.
    function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    assign accept = (state == IDLE) && bus.start && !bus.stop;

    // State register
    always_ff @(posedge ref_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stop_pend <= 1'b0;
            on_m1     <= '0;
            off_m1    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stop_pend <= stop_pend_nxt;
            if (accept) begin
                on_m1  <= eff_m1(bus.t_on);
                off_m1 <= eff_m1(bus.t_off);
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch inference).
        state_nxt     = state;
        cnt_nxt       = cnt;
        stop_pend_nxt = stop_pend;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.phase != '0) begin
                        state_nxt = PHASE;
                        cnt_nxt   = bus.phase - CNT_W'(1);
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = eff_m1(bus.t_on);
                    end
                end
            end
            PHASE: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = on_m1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (bus.stop) stop_pend_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = off_m1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LOW: begin
                if (bus.stop) stop_pend_nxt = 1'b1;
                // A stop arriving in the final low cycle still ends the run here.
                if (cnt == '0) begin
                    if (stop_pend || bus.stop) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = on_m1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == IDLE) stop_pend_nxt = 1'b0;
    end

    // Output logic: clk lags the HIGH state by one edge so it is a clean register.
    always_comb begin
        clk_nxt  = (state == HIGH);
        rise_nxt = (state == HIGH) && !clk_q;
        fall_nxt = (state != HIGH) && clk_q;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q  <= 1'b0;
            busy_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            clk_q  <= clk_nxt;
            busy_q <= busy_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    assign bus.clk      = clk_q;
    assign bus.busy     = busy_q;
    assign bus.rise_stb = rise_q;
    assign bus.fall_stb = fall_q;

`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
    logic [15:0] period_cnt;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (accept) begin
            period_cnt <= '0;
        end else if (state == HIGH && state_nxt == LOW) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    assign bus.period_cnt = period_cnt;
`else
`endif

endmodule

// File: tb/tb_clk_pattern_gen.sv
// Self-checking bench for clk_pattern_gen: directed scenarios plus randomized traffic
// compared against an arithmetic timeline model of the generated waveform.
module tb_clk_pattern_gen;

    localparam int CNT_W = 8;

    logic ref_clk = 1'b0;
    logic rst_n;

    clk_pattern_gen_if #(.CNT_W(CNT_W)) bus ();

    clk_pattern_gen #(.CNT_W(CNT_W)) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 ref_clk = ~ref_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: run described by start edge, phase and period; state derived arithmetically.
    int   n = 0;
    bit   m_run, m_high, m_clk;
    int   m_k, m_p, m_on, m_off, m_end;
    int   m_pcnt;
    logic [3:0] e_vec;   // {clk, busy, rise_stb, fall_stb}

    function automatic void model_reset();
        m_run  = 1'b0;
        m_high = 1'b0;
        m_clk  = 1'b0;
        m_pcnt = 0;
        m_end  = -1;
        e_vec  = 4'b0000;
    endfunction

    function automatic void model_edge(input bit st, input bit sp, input int ph, input int on, input int off);
        int  per;
        bit  new_high;
        bit  e_clk;
        n++;
        if (m_run) begin
            per = m_on + m_off;
            if (sp && m_end < 0) begin
                if (n - 1 - m_k < m_p) m_end = n;
                else m_end = m_k + m_p + ((n - 1 - m_k - m_p) / per + 1) * per;
            end
            if (n == m_end) m_run = 1'b0;
        end else if (st && !sp) begin
            m_run  = 1'b1;
            m_k    = n;
            m_p    = ph;
            m_on   = (on  == 0) ? 1 : on;
            m_off  = (off == 0) ? 1 : off;
            m_end  = -1;
            m_pcnt = 0;
        end
        per      = m_on + m_off;
        new_high = m_run && (n - m_k >= m_p) && (((n - m_k - m_p) % per) < m_on);
        e_clk    = m_high;
        e_vec    = {e_clk, m_run, e_clk && !m_clk, !e_clk && m_clk};
        if (m_high && !new_high && m_run) m_pcnt = (m_pcnt + 1) % 65536;
        m_clk  = e_clk;
        m_high = new_high;
    endfunction

    function automatic logic [3:0] dut_vec();
        return {bus.clk, bus.busy, bus.rise_stb, bus.fall_stb};
    endfunction

    task automatic set_cfg(input int ph, input int on, input int off);
        bus.phase = CNT_W'(ph);
        bus.t_on  = CNT_W'(on);
        bus.t_off = CNT_W'(off);
    endtask

    task automatic cycle(input bit st, input bit sp);
        bus.start = st;
        bus.stop  = sp;
        @(posedge ref_clk);
        model_edge(st, sp, int'(bus.phase), int'(bus.t_on), int'(bus.t_off));
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic drain(input string name);
        cycle(1'b0, 1'b1);
        checks++;
        if (dut_vec() !== e_vec) begin
            errors++;
            $display("FAIL %s drain stop edge %0d: clk/busy/rise/fall got %b want %b", name, n, dut_vec(), e_vec);
        end
        for (int i = 0; i < 1000 && bus.busy === 1'b1; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL %s drain edge %0d: clk/busy/rise/fall got %b want %b", name, n, dut_vec(), e_vec);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s drain timeout: busy got %b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 0);
        model_reset();
        repeat (2) @(posedge ref_clk);
        #1;
        checks++;
        if (dut_vec() !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got %b want 0000", dut_vec());
        end
`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
        checks++;
        if (bus.period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset period_cnt: got %0d want 0", bus.period_cnt);
        end
`endif
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== e_vec) begin
            errors++;
            $display("FAIL reset idle: got %b want %b", dut_vec(), e_vec);
        end
    endtask

    task automatic test_phase7();
        set_cfg(7, 5, 5);
        cycle(1'b1, 1'b0);
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL phase7 k+%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            if (i == 8 || i == 13 || i == 18) begin
                checks++;
                if ({bus.clk, bus.rise_stb, bus.fall_stb} !== ((i == 13) ? 3'b001 : 3'b110)) begin
                    errors++;
                    $display("FAIL phase7 edge k+%0d: clk/rise/fall got %b", i, {bus.clk, bus.rise_stb, bus.fall_stb});
                end
            end
        end
        drain("phase7");
    endtask

    task automatic test_duty();
        set_cfg(0, 1, 3);
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            // Extra starts and config churn while busy must have no effect.
            set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            cycle($urandom_range(0, 2) == 0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL duty k+%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            checks++;
            if (bus.clk !== ((i - 1) % 4 == 0)) begin
                errors++;
                $display("FAIL duty pattern k+%0d: clk got %b want %b", i, bus.clk, (i - 1) % 4 == 0);
            end
        end
        drain("duty");
    endtask

    task automatic test_zero();
        set_cfg(2, 0, 0);
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL zero k+%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            checks++;
            if (bus.clk !== (i >= 3 && (i - 3) % 2 == 0)) begin
                errors++;
                $display("FAIL zero toggle k+%0d: clk got %b", i, bus.clk);
            end
        end
        drain("zero");
    endtask

    task automatic test_stop();
        set_cfg(3, 4, 2);
        // Stop during the phase delay
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_vec() !== e_vec || bus.busy !== 1'b0 || bus.clk !== 1'b0) begin
                errors++;
                $display("FAIL stop_phase +%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            cycle(1'b0, 1'b0);
        end
        // Stop in the middle of the high time
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, i == 5);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL stop_high k+%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            checks++;
            if ({bus.clk, bus.busy} !== {(i >= 4 && i <= 7), (i < 9)}) begin
                errors++;
                $display("FAIL stop_high timing k+%0d: clk/busy got %b", i, {bus.clk, bus.busy});
            end
        end
        // Start and stop together in IDLE
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_vec() !== e_vec || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL start_stop +%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            cycle(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_high();
        set_cfg(0, 4, 2);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        checks++;
        if (bus.clk !== 1'b1 || dut_vec() !== e_vec) begin
            errors++;
            $display("FAIL rst_mid pre: clk/busy/rise/fall got %b want %b", dut_vec(), e_vec);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid async: got %b want 0000", dut_vec());
        end
        model_reset();
        #2 rst_n = 1'b1;
        set_cfg(3, 4, 2);
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL rst_mid restart k+%0d: got %b want %b", i, dut_vec(), e_vec);
            end
            checks++;
            if (bus.rise_stb !== (i == 4)) begin
                errors++;
                $display("FAIL rst_mid phase k+%0d: rise got %b", i, bus.rise_stb);
            end
        end
        drain("rst_mid");
    endtask

    task automatic test_max();
        set_cfg(255, 255, 255);
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 520; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL max k+%0d: clk/busy/rise/fall got %b want %b", i, dut_vec(), e_vec);
            end
            if (i == 256 || i == 511) begin
                checks++;
                if ({bus.rise_stb, bus.fall_stb} !== ((i == 256) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL max edge k+%0d: rise/fall got %b", i, {bus.rise_stb, bus.fall_stb});
                end
            end
        end
        drain("max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++;
                $display("FAIL random edge %0d: clk/busy/rise/fall got %b want %b", n, dut_vec(), e_vec);
            end
`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
            checks++;
            if (int'(bus.period_cnt) !== m_pcnt) begin
                errors++;
                $display("FAIL random period_cnt edge %0d: got %0d want %0d", n, bus.period_cnt, m_pcnt);
            end
`endif
        end
        drain("random");
    endtask

`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
    task automatic test_period_cnt();
        set_cfg(0, 1, 1);
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (int'(bus.period_cnt) !== m_pcnt) begin
                errors++;
                $display("FAIL period_cnt k+%0d: got %0d want %0d", i, bus.period_cnt, m_pcnt);
            end
        end
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.period_cnt !== 16'd10 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL period_cnt hold +%0d: got %0d busy %b want 10 busy 0", i, bus.period_cnt, bus.busy);
            end
            cycle(1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (bus.period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL period_cnt clear: got %0d want 0", bus.period_cnt);
        end
        drain("period_cnt");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_phase7();
        test_duty();
        test_zero();
        test_stop();
        test_reset_mid_high();
        test_max();
`ifdef CLK_PATTERN_GEN_PERIOD_CNT_EN
        test_period_cnt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
